// File: rtl/fp_alu_pkg.sv
// Shared opcode and flag encodings for the pipelined floating-point ALU.
package fp_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int FLAGS_W  = 3;
    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc
    import fp_alu_pkg::*;
#(
    parameter int W  = 25,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] cnt
);

    // Later iterations win, so the highest set bit decides the count.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (x[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_alu_pipe.sv
// Three-stage add/sub/mul floating-point pipeline with valid/ready flow
// control, flush-to-zero denormals and truncating rounding.
module fp_alu_pipe
    import fp_alu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [1:0]         op,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W-1:0]       r,
    output logic [FLAGS_W-1:0] flags,
    output logic               exception,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int N    = MAN_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int LZW  = $clog2(N + 1);
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, align or multiply
    logic               sa, sb, sb_eff, za, zb, a_ge;
    logic [EXP_W-1:0]   ea, eb, big_e, d;
    logic [MAN_W-1:0]   fa, fb;
    logic [MAN_W:0]     ma, mb, big_m, small_m;
    logic [EW-1:0]      mul_e;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign za      = (ea == '0);
    assign zb      = (eb == '0);
    assign ma      = za ? '0 : {1'b1, fa};
    assign mb      = zb ? '0 : {1'b1, fb};
    assign sb_eff  = sb ^ (op == OP_SUB);
    assign a_ge    = {ea, ma} >= {eb, mb};
    assign big_e   = a_ge ? ea : eb;
    assign d       = a_ge ? ea - eb : eb - ea;
    assign big_m   = a_ge ? ma : mb;
    assign small_m = a_ge ? mb : ma;
    assign mul_e   = EW'(ea) + EW'(eb) - EW'(BIAS);

    logic               s1_valid, s1_mul, s1_nan, s1_zero, s1_sign, s1_sub;
    logic [EW-1:0]      s1_exp;
    logic [MAN_W:0]     s1_ma, s1_mb;
    logic [PW-1:0]      s1_prod;

    // Stage 2: add/normalise
    logic [N-1:0]       sum;
    logic [LZW-1:0]     lz;
    logic               mul_hi, add_zero;
    logic [MAN_W-1:0]   add_man, mul_man;
    logic [EW-1:0]      add_exp, mul_exp;

    assign sum = s1_sub ? {1'b0, s1_ma} - {1'b0, s1_mb}
                        : {1'b0, s1_ma} + {1'b0, s1_mb};

    fp_lzc #(.W(N)) u_lzc (
        .x   (sum),
        .cnt (lz)
    );

    assign add_zero = (sum == '0);
    assign add_man  = MAN_W'((sum << lz) >> 1);
    assign add_exp  = s1_exp + EW'(1) - EW'(lz);
    assign mul_hi   = s1_prod[PW-1];
    assign mul_man  = mul_hi ? MAN_W'(s1_prod >> (MAN_W + 1))
                             : MAN_W'(s1_prod >> MAN_W);
    assign mul_exp  = s1_exp + (mul_hi ? EW'(1) : EW'(0));

    logic               s2_valid, s2_nan, s2_zero, s2_sign;
    logic [EW-1:0]      s2_exp;
    logic [MAN_W-1:0]   s2_man;

    // Stage 3: range check and pack; exponent is two's complement
    logic [W-1:0]       pack_r;
    logic [FLAGS_W-1:0] pack_f;
    logic               e_neg;

    assign e_neg = s2_exp[EW-1];

    always_comb begin
        pack_r = {s2_sign, EXP_W'(s2_exp), s2_man};
        pack_f = '0;
        if (s2_nan) begin
            pack_r           = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pack_f[FLAG_INV] = 1'b1;
        end else if (s2_zero) begin
            pack_r = {s2_sign, {(W-1){1'b0}}};
        end else if (!e_neg && s2_exp >= EXP_MAX) begin
            pack_r           = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_f[FLAG_OVF] = 1'b1;
        end else if (e_neg || s2_exp == '0) begin
            pack_r           = {s2_sign, {(W-1){1'b0}}};
            pack_f[FLAG_UNF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            r         <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_mul   <= (op == OP_MUL);
            s1_nan   <= (&ea) || (&eb) || (op == OP_RSV);
            s1_zero  <= za || zb;
            s1_sign  <= (op == OP_MUL) ? sa ^ sb : (a_ge ? sa : sb_eff);
            s1_sub   <= sa ^ sb_eff;
            s1_exp   <= (op == OP_MUL) ? mul_e : EW'(big_e);
            s1_ma    <= big_m;
            s1_mb    <= small_m >> d;
            s1_prod  <= PW'(ma) * PW'(mb);

            s2_valid <= s1_valid;
            s2_nan   <= s1_nan;
            s2_zero  <= s1_mul ? s1_zero : add_zero;
            s2_sign  <= (!s1_mul && add_zero) ? 1'b0 : s1_sign;
            s2_exp   <= s1_mul ? mul_exp : add_exp;
            s2_man   <= s1_mul ? mul_man : add_man;

            out_valid <= s2_valid;
            r         <= pack_r;
            flags     <= pack_f;
        end
    end

    assign exception = |flags;

endmodule
